// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
//   state_t     - FSM state encoding (IDLE, CALC, DONE)
//   iter_count  - number of CALC iterations for a WIDTH/BITS_PER_CYCLE pair
//   params_ok   - elaboration-time legality check of the parameter pair
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned iter_count(input int unsigned width,
                                             input int unsigned bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // WIDTH >= 2, BITS_PER_CYCLE in {1,2,4} and dividing WIDTH.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned bits_per_cycle);
    bit bpc_legal;
    bpc_legal = (bits_per_cycle == 1) || (bits_per_cycle == 2) || (bits_per_cycle == 4);
    return (width >= 2) && bpc_legal && ((width % bits_per_cycle) == 0);
  endfunction

endpackage

// File: rtl/mult_step_unit.sv
// One iteration of the shift-add multiplier: sums BITS_PER_CYCLE rows of the
// multiplicand (gated by the low multiplier bits) and adds them into the
// accumulator at the bit position selected by the iteration count.
// Ports:
//   mcand      - multiplicand magnitude
//   bits       - multiplier bits retired this iteration
//   step       - iteration index (shift position = step * BITS_PER_CYCLE)
//   acc        - current accumulator
//   acc_next_c - accumulator after this iteration (combinational)
module mult_step_unit #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned CNT_W          = 4
) (
  input  logic [WIDTH-1:0]          mcand,
  input  logic [BITS_PER_CYCLE-1:0] bits,
  input  logic [CNT_W-1:0]          step,
  input  logic [2*WIDTH-1:0]        acc,
  output logic [2*WIDTH-1:0]        acc_next_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] rows;
  logic [31:0]   shamt;

  // Partial product of this iteration, then placed at the current shift position.
  always_comb begin
    rows  = '0;
    shamt = 32'(step) * BITS_PER_CYCLE;
    for (int j = 0; j < int'(BITS_PER_CYCLE); j++) begin
      if (bits[j]) begin
        rows = rows + (PW'(mcand) << j);
      end
    end
    acc_next_c = acc + (rows << shamt);
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned, retiring
// BITS_PER_CYCLE multiplier bits per clock, with valid/ready on both sides.
// Optional macro ZERO_SKIP_EN: finish early once the remaining multiplier bits
// are all zero (latency 1..N instead of a fixed N).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_valid/in_ready, a, b, signed_mode - operand handshake and operands
//   out_valid/out_ready, product         - result handshake and registered product
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned N  = iter_count(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = 2 * WIDTH;

  if (!params_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
    $error("seq_shift_add_multiplier: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  state_t            state, state_next;
  logic [WIDTH-1:0]  mcand, mplier;
  logic              neg;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;

  logic              load, step_en, finish, last_c;
  logic [WIDTH-1:0]  a_mag, b_mag, mplier_shift;
  logic [PW-1:0]     acc_next_c;

  // Operand magnitudes; the most negative value negates onto itself, which
  // read as unsigned is exactly 2^(WIDTH-1).
  assign a_mag        = (signed_mode && a[WIDTH-1]) ? WIDTH'(-a) : a;
  assign b_mag        = (signed_mode && b[WIDTH-1]) ? WIDTH'(-b) : b;
  assign mplier_shift = mplier >> BITS_PER_CYCLE;

`ifdef ZERO_SKIP_EN
  // Remaining multiplier bits all zero: nothing more to add.
  assign last_c = (cnt == CW'(N - 1)) || (mplier_shift == '0);
`else
  assign last_c = (cnt == CW'(N - 1));
`endif

  mult_step_unit #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (CW)
  ) u_step (
    .mcand      (mcand),
    .bits       (mplier[BITS_PER_CYCLE-1:0]),
    .step       (cnt),
    .acc        (acc),
    .acc_next_c (acc_next_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step_en = 1'b1;
        if (last_c) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      product   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      if (load) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        acc    <= '0;
        cnt    <= '0;
      end
      if (step_en) begin
        acc    <= acc_next_c;
        mplier <= mplier_shift;
        cnt    <= cnt + CW'(1);
      end
      if (finish) begin
        product <= neg ? PW'(-acc_next_c) : acc_next_c;
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench: the driver pushes expected product and expected
// out_valid cycle per accepted job; monitors pop and compare on output.
module tb_seq_shift_add_multiplier;

  typedef struct {
    logic [31:0] prod;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        in_valid2, in_ready2, signed_mode2, out_valid2, out_ready2;
  logic [15:0] a2, b2;
  logic [31:0] product2;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_add_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready), .product(product));

  seq_shift_add_multiplier #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .signed_mode(signed_mode2),
    .out_valid(out_valid2), .out_ready(out_ready2), .product(product2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // CALC cycles for the 8-bit instance (BITS_PER_CYCLE=1).
  function automatic int lat8(input logic [7:0] bv, input bit s);
`ifdef ZERO_SKIP_EN
    logic [7:0] m;
    int         n;
    m = (s && bv[7]) ? 8'(-bv) : bv;
    n = 1;
    for (int i = 1; i < 8; i++) if ((m >> i) != 8'd0) n = i + 1;
    return n;
`else
    return 8;
`endif
  endfunction

  // Monitor for the 8-bit instance.
  bit prev_ov1 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov1 = 1'b0;
    end else begin
      if (out_valid && !prev_ov1) begin
        if (q1.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
        else                check("latency", 32'(cyc), 32'(q1[0].cyc));
      end
      if (out_valid && out_ready && q1.size() != 0) begin
        check("product", 32'(product), q1[0].prod);
        void'(q1.pop_front());
      end
      prev_ov1 = out_valid;
    end
  end

  // Monitor for the 16-bit, 2-bits-per-cycle instance.
  bit prev_ov2 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ov2 = 1'b0;
    end else begin
      if (out_valid2 && !prev_ov2) begin
        if (q2.size() == 0) check("unexpected_out_valid2", 32'(out_valid2), 32'd0);
        else                check("latency2", 32'(cyc), 32'(q2[0].cyc));
      end
      if (out_valid2 && out_ready2 && q2.size() != 0) begin
        check("product2", product2, q2[0].prod);
        void'(q2.pop_front());
      end
      prev_ov2 = out_valid2;
    end
  end

  // Present one job to the 8-bit instance; expectation pushed when push is set.
  task automatic send(input logic [7:0] av, input logic [7:0] bv, input bit s,
                      input logic [15:0] exp_p, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = av; b = bv; signed_mode = s;
    e.prod = 32'(exp_p);
    e.cyc  = cyc + 1 + lat8(bv, s);
    if (push) q1.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q1.size() != 0 || q2.size() != 0 || !in_ready) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(q1.size() + q2.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; signed_mode2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_product", 32'(product), 32'd0);

    // Unsigned and signed directed vectors.
    send(8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
    send(8'hFD,  8'd5,   1'b1, 16'hFFF1, 1'b1);
    send(8'h80,  8'h80,  1'b1, 16'h4000, 1'b1);
    send(8'h80,  8'h80,  1'b0, 16'h4000, 1'b1);
    send(8'hFD,  8'd5,   1'b0, 16'h04F1, 1'b1);
    send(8'hFF,  8'hFF,  1'b1, 16'h0001, 1'b1);
    send(8'h7F,  8'h80,  1'b1, 16'hC080, 1'b1);
    send(8'd0,   8'd99,  1'b0, 16'h0000, 1'b1);
    wait_idle();

    // Backpressure: hold out_ready low for 5 cycles of out_valid.
    out_ready = 1'b0;
    send(8'd200, 8'd2, 1'b0, 16'h0190, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_product", 32'(product), 32'h0190);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_hold_product", 32'(product), 32'h0190);
    wait_idle();

    // Reset at iteration 4 of a job; that job must never appear.
    send(8'd100, 8'd255, 1'b0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    send(8'd12, 8'd12, 1'b0, 16'd144, 1'b1);
    wait_idle();

    // Early-finish candidates (fixed latency unless ZERO_SKIP_EN).
    send(8'd77, 8'd1, 1'b0, 16'd77, 1'b1);
    send(8'd77, 8'd0, 1'b0, 16'd0, 1'b1);
    wait_idle();

    // 16-bit, two bits per cycle.
    @(posedge clk); #1;
    in_valid2 = 1'b1; a2 = 16'hFFFF; b2 = 16'hFFFF; signed_mode2 = 1'b0;
    check("in_ready2", 32'(in_ready2), 32'd1);
    e.prod = 32'hFFFE0001;
    e.cyc  = cyc + 1 + 8;
    q2.push_back(e);
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    wait_idle();

    check("q1_empty", 32'(q1.size()), 32'd0);
    check("q2_empty", 32'(q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
